instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the MIPS pipeline: owns the program counter, selects the next PC
//  (PC+4, branch target or jump target), and issues word fetches to instruction memory.
//  Delivers {pc, pc+4, instr} into the IF/ID register consumed by decode.
//  Absorbs memory latency, decode back-pressure (stall) and redirects (flush).
// PARAMETERS
//  ADDR_W        32     PC / memory address width
//  DATA_W        32     instruction width
//  RESET_VECTOR  32'h0  PC value loaded on Reset
// PORTS
//  clk            in   1       rising-edge clock
//  Reset          in   1       synchronous, active-high reset
//  stall          in   1       decode cannot accept; hold IF/ID contents
//  branch_taken   in   1       resolved taken branch (redirect)
//  branch_target  in   ADDR_W  branch destination
//  jump           in   1       jump redirect
//  jump_target    in   ADDR_W  jump destination
//  imem_req       out  1       fetch request; held until imem_ack
//  imem_addr      out  ADDR_W  fetch address; stable while imem_req=1
//  imem_ack       in   1       1-cycle pulse: imem_rdata valid, request retired
//  imem_rdata     in   DATA_W  fetched instruction
//  if_valid       out  1       IF/ID holds a valid instruction
//  if_pc          out  ADDR_W  PC of the IF/ID instruction
//  if_pc_plus4    out  ADDR_W  if_pc+4 (mod 2^ADDR_W)
//  if_instr       out  DATA_W  instruction word
// BEHAVIOUR
//  - Reset: pc=RESET_VECTOR, state=FETCH, imem_req=0 during the Reset cycle; if_valid=0,
//    if_pc=0, if_pc_plus4=0, if_instr=0, hold buffer empty. Reset wins over all inputs,
//    including mid-transaction (an outstanding ack after Reset is treated as a new-PC ack;
//    memory must drop requests on Reset).
//  - redirect = branch_taken | jump; target = branch_taken ? branch_target : jump_target
//    (branch has priority). redirect clears if_valid next cycle regardless of stall.
//  - accept = !if_valid | !stall (IF/ID slot free or drained this cycle).
//  - FSM states:
//    FETCH: imem_req=1, imem_addr=pc.
//      redirect & !ack -> pc_pend<=target, DROP.  redirect & ack -> pc<=target, FETCH.
//      ack & accept -> IF/ID<={pc,pc+4,rdata}, if_valid=1, pc<=pc+4, FETCH.
//      ack & !accept -> hold<={pc,rdata}, pc<=pc+4, HOLD.  else stay.
//    DROP: imem_req=1, imem_addr=old pc (unchanged). ack -> discard, pc<=pc_pend, FETCH.
//      A further redirect in DROP overwrites pc_pend (youngest wins).
//    HOLD: imem_req=0. redirect -> drop hold, pc<=target, FETCH.
//      accept -> IF/ID<=hold, if_valid=1, FETCH.
//  - Best-case throughput 1 instr/cycle with single-cycle ack; ack-to-if_valid latency 1 clk.
//  - If IF/ID not loaded and stall=0, if_valid<=0 (bubble). With stall=1 IF/ID is frozen.
//  - PC arithmetic unsigned, wraps 32'hFFFF_FFFC -> 32'h0. Targets used as given (no check).
//  - imem_ack outside FETCH/DROP is ignored.
// STRUCTURE
//  - Shared header fetch_defs.vh: FSM encodings (FETCH/DROP/HOLD), PC_INC=4.
//  - One sub-module: if_id_reg (valid/pc/pc_plus4/instr with load, flush, hold).
//  - FSM, PC, pc_pend, hold buffer and next-PC mux live in instr_fetch_unit.
// TESTING
//  1. Reset, ack every cycle from req, rdata=addr^32'hA5 -> if_pc 0,4,8,12 on consecutive
//     cycles, if_valid=1 from 2nd cycle after Reset release.
//  2. ack delayed 3 cycles -> imem_addr stable while req=1; if_valid has 3-cycle bubbles.
//  3. stall=1 while ack for pc=8 arrives -> HOLD, req=0, IF/ID keeps pc=4; stall=0 ->
//     if_pc=8 next cycle, fetch resumes at 12.
//  4. jump=1, jump_target=0x100 while req for 0x10 outstanding -> DROP; after ack the
//     0x10 data never appears; next imem_addr=0x100, if_valid=0 one cycle after jump.
//  5. branch_taken (0x200) and jump (0x300) same cycle -> next fetch 0x200.
//  6. RESET_VECTOR=32'hFFFF_FFF8 -> if_pc FFFF_FFF8, FFFF_FFFC, 0; Reset asserted mid-
//     wait -> next cycle if_valid=0, imem_addr=RESET_VECTOR.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch-stage definitions
// Purpose: FSM state encodings and PC increment used by the fetch unit.
package instr_fetch_unit_pkg;

    // FETCH: request outstanding for pc
    // DROP : request outstanding for a stale pc, its data is discarded
    // HOLD : fetched word parked because IF/ID could not accept it
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// rtl/instr_fetch_unit_if_id_reg.sv - IF/ID pipeline register
// Purpose: holds {valid, pc, pc+4, instr} for decode.
// Ports:
//   clk, Reset              clock, synchronous active-high reset
//   flush                   redirect: invalidate regardless of stall
//   load                    capture ld_* and mark valid
//   stall                   decode not accepting: freeze contents
//   ld_pc/ld_pc_plus4/ld_instr  values to capture
//   valid/pc/pc_plus4/instr register outputs
module if_id_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              load,
    input  logic              stall,
    input  logic [ADDR_W-1:0] ld_pc,
    input  logic [ADDR_W-1:0] ld_pc_plus4,
    input  logic [DATA_W-1:0] ld_instr,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] instr
);

    always_ff @(posedge clk) begin
        if (Reset) begin
            valid    <= 1'b0;
            pc       <= '0;
            pc_plus4 <= '0;
            instr    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            pc       <= ld_pc;
            pc_plus4 <= ld_pc_plus4;
            instr    <= ld_instr;
        end else if (!stall) begin
            // decode drained the slot and nothing new arrived: bubble
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC, next-PC select, imem requests
// Purpose: owns the PC, issues word fetches, feeds the IF/ID register and
//   absorbs memory latency, decode stall and branch/jump redirects.
// Ports:
//   clk, Reset                    clock, synchronous active-high reset
//   stall                         decode cannot accept
//   branch_taken/branch_target    branch redirect (priority over jump)
//   jump/jump_target              jump redirect
//   imem_req/imem_addr            fetch request, held until imem_ack
//   imem_ack/imem_rdata           one-cycle completion with data
//   if_valid/if_pc/if_pc_plus4/if_instr  IF/ID contents
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter int              DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [DATA_W-1:0] if_instr
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] pc_pend, pc_pend_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] hold_pc;
    logic [DATA_W-1:0] hold_instr;
    logic              hold_ld;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              accept;

    logic              ifid_load;
    logic [ADDR_W-1:0] ifid_ld_pc;
    logic [ADDR_W-1:0] ifid_ld_pc_plus4;
    logic [DATA_W-1:0] ifid_ld_instr;

    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign accept   = !if_valid || !stall;
    assign pc_inc   = pc + ADDR_W'(PC_INC);

    // The request drops in the Reset cycle itself so memory never sees a
    // fetch for a PC that is about to be replaced.
    assign imem_req  = !Reset && (state != HOLD);
    assign imem_addr = pc;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pc_pend_nxt   = pc_pend;
        hold_ld       = 1'b0;
        ifid_load     = 1'b0;
        ifid_ld_pc    = pc;
        ifid_ld_instr = imem_rdata;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        pc_nxt = target;
                    end else begin
                        // request cannot be withdrawn; wait for it and discard
                        pc_pend_nxt = target;
                        state_nxt   = DROP;
                    end
                end else if (imem_ack) begin
                    pc_nxt = pc_inc;
                    if (accept) begin
                        ifid_load = 1'b1;
                    end else begin
                        hold_ld   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            DROP: begin
                // youngest redirect wins
                if (redirect) begin
                    pc_pend_nxt = target;
                end
                if (imem_ack) begin
                    pc_nxt    = redirect ? target : pc_pend;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else if (accept) begin
                    ifid_load     = 1'b1;
                    ifid_ld_pc    = hold_pc;
                    ifid_ld_instr = hold_instr;
                    state_nxt     = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign ifid_ld_pc_plus4 = ifid_ld_pc + ADDR_W'(PC_INC);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= FETCH;
            pc         <= RESET_VECTOR;
            pc_pend    <= RESET_VECTOR;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pc_pend <= pc_pend_nxt;
            if (hold_ld) begin
                hold_pc    <= pc;
                hold_instr <= imem_rdata;
            end
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk         (clk),
        .Reset       (Reset),
        .flush       (redirect),
        .load        (ifid_load),
        .stall       (stall),
        .ld_pc       (ifid_ld_pc),
        .ld_pc_plus4 (ifid_ld_pc_plus4),
        .ld_instr    (ifid_ld_instr),
        .valid       (if_valid),
        .pc          (if_pc),
        .pc_plus4    (if_pc_plus4),
        .instr       (if_instr)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        Reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;

    logic        rv_req;
    logic [31:0] rv_addr;
    logic        rv_ack;
    logic [31:0] rv_rdata;
    logic        rv_valid;
    logic [31:0] rv_pc;
    logic [31:0] rv_pc_plus4;
    logic [31:0] rv_instr;
    logic        rv_en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory model controls
    int          delay  = 0;
    int          budget = 0;
    int          wait_cnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    exp_t e;

    instr_fetch_unit dut (
        .clk           (clk),
        .Reset         (Reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_instr      (if_instr)
    );

    instr_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_rv (
        .clk           (clk),
        .Reset         (Reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (rv_req),
        .imem_addr     (rv_addr),
        .imem_ack      (rv_ack),
        .imem_rdata    (rv_rdata),
        .if_valid      (rv_valid),
        .if_pc         (rv_pc),
        .if_pc_plus4   (rv_pc_plus4),
        .if_instr      (rv_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pc4);
        exp_t x;
        x.pc       = pc;
        x.pc_plus4 = pc4;
        x.instr    = pc ^ 32'hA5;
        exp_q.push_back(x);
    endtask

    task automatic reset_dut(input int dly, input int bud);
        Reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        branch_target = '0;
        jump_target   = '0;
        rv_en         = 1'b0;
        budget        = 0;
        cyc_n(2);
        delay  = dly;
        budget = bud;
        Reset  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) cyc_n(1);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // main memory model: acks after `delay` waiting cycles, limited by `budget`
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req && prev_req && !prev_ack)
                chk("addr_stable", imem_addr, prev_addr);
            prev_req  = imem_req;
            prev_addr = imem_addr;
            imem_ack  = 1'b0;
            if (imem_req && budget > 0) begin
                if (wait_cnt >= delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ 32'hA5;
                    budget--;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!imem_req) begin
                wait_cnt = 0;
            end
            prev_ack = imem_ack;
        end
    end

    // memory for the reset-vector instance: single-cycle ack when enabled
    initial begin
        rv_ack   = 1'b0;
        rv_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            rv_ack   = rv_en && rv_req;
            rv_rdata = rv_addr ^ 32'hA5;
        end
    end

    // monitor: every instruction decode takes is compared against the queue
    always @(negedge clk) begin
        if (!Reset && if_valid && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual pc=%h required=no output", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_pc_plus4", if_pc_plus4, e.pc_plus4);
                chk("sb_instr", if_instr, e.instr);
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0; rv_en = 1'b0;

        // reset state
        cyc_n(1);
        @(negedge clk);
        chk("rst_if_valid", {31'b0, if_valid}, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_pc_plus4", if_pc_plus4, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_imem_req", {31'b0, imem_req}, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_rv_addr", rv_addr, 32'hFFFF_FFF8);

        // 1: back-to-back single-cycle acks
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC); push(32'hC, 32'h10);
        reset_dut(0, 4);
        @(negedge clk);
        chk("t1_valid_c1", {31'b0, if_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            cyc_n(1);
            @(negedge clk);
            chk("t1_valid", {31'b0, if_valid}, 1);
            chk("t1_pc", if_pc, 32'(i * 4));
        end
        wait_drain("t1_drain", 20);

        // 2: 3-cycle memory latency
        pop_cyc.delete();
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC);
        reset_dut(3, 3);
        wait_drain("t2_drain", 40);
        chk("t2_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            chk("t2_gap1", pop_cyc[1] - pop_cyc[0], 4);
            chk("t2_gap2", pop_cyc[2] - pop_cyc[1], 4);
        end

        // 3: stall while ack for pc=8 arrives
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC); push(32'hC, 32'h10);
        reset_dut(0, 4);
        cyc_n(2);
        stall = 1'b1;
        cyc_n(1);
        @(negedge clk);
        chk("t3_hold_req", {31'b0, imem_req}, 0);
        chk("t3_hold_pc", if_pc, 32'h4);
        chk("t3_hold_valid", {31'b0, if_valid}, 1);
        cyc_n(1);
        stall = 1'b0;
        cyc_n(1);
        @(negedge clk);
        chk("t3_pc8", if_pc, 32'h8);
        chk("t3_valid8", {31'b0, if_valid}, 1);
        chk("t3_req", {31'b0, imem_req}, 1);
        chk("t3_addr12", imem_addr, 32'hC);
        wait_drain("t3_drain", 20);

        // 4: jump while fetch of 0x10 outstanding, under stall
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC);
        reset_dut(0, 4);
        cyc_n(4);
        stall = 1'b1;
        cyc_n(1);
        jump = 1'b1;
        jump_target = 32'h100;
        @(negedge clk);
        chk("t4_addr10", imem_addr, 32'h10);
        chk("t4_pcC_held", if_pc, 32'hC);
        cyc_n(1);
        jump = 1'b0;
        stall = 1'b0;
        push(32'h100, 32'h104);
        budget = 2;
        @(negedge clk);
        chk("t4_flush_valid", {31'b0, if_valid}, 0);
        chk("t4_drop_addr", imem_addr, 32'h10);
        cyc_n(1);
        @(negedge clk);
        chk("t4_addr100", imem_addr, 32'h100);
        chk("t4_req100", {31'b0, imem_req}, 1);
        wait_drain("t4_drain", 20);

        // 5: branch and jump together; branch wins (redirect with ack)
        push(32'h0, 32'h4); push(32'h200, 32'h204);
        reset_dut(0, 1);
        cyc_n(2);
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        jump          = 1'b1;
        jump_target   = 32'h300;
        budget        = 1;
        cyc_n(1);
        branch_taken = 1'b0;
        jump         = 1'b0;
        budget       = 1;
        @(negedge clk);
        chk("t5_addr200", imem_addr, 32'h200);
        chk("t5_valid", {31'b0, if_valid}, 0);
        wait_drain("t5_drain", 20);

        // 6: reset vector near the top of the address space, wrap, reset mid-wait
        reset_dut(0, 0);
        rv_en = 1'b1;
        cyc_n(1);
        @(negedge clk);
        chk("t6_valid0", {31'b0, rv_valid}, 1);
        chk("t6_pc0", rv_pc, 32'hFFFF_FFF8);
        chk("t6_pc4_0", rv_pc_plus4, 32'hFFFF_FFFC);
        chk("t6_instr0", rv_instr, 32'hFFFF_FF5D);
        cyc_n(1);
        @(negedge clk);
        chk("t6_pc1", rv_pc, 32'hFFFF_FFFC);
        chk("t6_pc4_1", rv_pc_plus4, 32'h0);
        cyc_n(1);
        rv_en = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        chk("t6_pc2", rv_pc, 32'h0);
        chk("t6_pc4_2", rv_pc_plus4, 32'h4);
        chk("t6_instr2", rv_instr, 32'hA5);
        chk("t6_rst_req", {31'b0, rv_req}, 0);
        cyc_n(1);
        @(negedge clk);
        chk("t6_rst_valid", {31'b0, rv_valid}, 0);
        chk("t6_rst_addr", rv_addr, 32'hFFFF_FFF8);
        chk("t6_rst_pc", rv_pc, 32'h0);
        cyc_n(1);
        Reset = 1'b0;
        @(negedge clk);
        chk("t6_req_after", {31'b0, rv_req}, 1);
        chk("t6_addr_after", rv_addr, 32'hFFFF_FFF8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
